// File: rtl/ocp_pkg.sv
// ocp_pkg: OCP command, response and slave-state encodings shared by master and slave
package ocp_pkg;
    typedef enum logic [2:0] {
        CMD_IDLE = 3'd0,
        CMD_WR   = 3'd1,
        CMD_RD   = 3'd2,
        CMD_RDEX = 3'd3,
        CMD_RDL  = 3'd4,
        CMD_WRNP = 3'd5,
        CMD_WRC  = 3'd6,
        CMD_BCST = 3'd7
    } ocp_cmd_e;
    typedef enum logic [1:0] {
        RESP_NULL = 2'd0,
        RESP_DVA  = 2'd1,
        RESP_FAIL = 2'd2,
        RESP_ERR  = 2'd3
    } ocp_resp_e;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCEPT = 2'd2,
        S_RESP   = 2'd3
    } slave_state_e;
endpackage

// File: rtl/ocp_slave_regfile.sv
// ocp_slave_regfile: byte register file, synchronous write and clear, combinational read
module ocp_slave_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
    assign rdata = mem[addr];
    always_ff @(posedge Clk) begin
        if (reset)
            mem <= '{default: '0};
        else if (we)
            mem[addr] <= wdata;
    end
endmodule

// File: rtl/ocp_slave_fsm.sv
// ocp_slave_fsm: OCP request/response slave with delayed accept over a local register file
module ocp_slave_fsm
    import ocp_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 64,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    DEPTH_LOG2   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    ACCEPT_DELAY = 0
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  EnableClk,
    input  logic [2:0]            MCmd,
    input  logic [ADDR_WIDTH-1:0] MAddr,
    input  logic [DATA_WIDTH-1:0] MData,
    output logic                  SCmdAccept,
    output logic [1:0]            SResp,
    output logic [DATA_WIDTH-1:0] SData,
    output logic                  err
);
    slave_state_e          state;
    logic [3:0]            cnt;
    logic                  hit, we, ok, silent;
    logic [DATA_WIDTH-1:0] rd_data;
    assign hit    = MAddr[ADDR_WIDTH-1:DEPTH_LOG2] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2];
    assign ok     = hit && (MCmd == CMD_WR || MCmd == CMD_WRNP || MCmd == CMD_RD);
    assign silent = MCmd == CMD_WR || MCmd == CMD_IDLE;
    assign we     = EnableClk && state == S_ACCEPT && hit && (MCmd == CMD_WR || MCmd == CMD_WRNP);
    ocp_slave_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_regfile (
        .Clk  (Clk),
        .reset(reset),
        .we   (we),
        .addr (MAddr[DEPTH_LOG2-1:0]),
        .wdata(MData),
        .rdata(rd_data)
    );
    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            SCmdAccept <= 1'b0;
            SResp      <= RESP_NULL;
            SData      <= '0;
            err        <= 1'b0;
        end else if (EnableClk) begin
            SCmdAccept <= 1'b0;
            SResp      <= RESP_NULL;
            SData      <= '0;
            err        <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (MCmd == CMD_IDLE) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end else if (cnt == 4'd1) begin
                        state      <= S_ACCEPT;
                        SCmdAccept <= 1'b1;
                    end else
                        cnt <= cnt - 4'd1;
                end
                S_ACCEPT: begin
                    // IDLE at the execute edge is a withdrawn request: flag it, no response
                    state <= silent ? S_IDLE : S_RESP;
                    err   <= !ok;
                    SResp <= silent ? RESP_NULL : MCmd == CMD_WRC ? RESP_FAIL : ok ? RESP_DVA : RESP_ERR;
                    SData <= (hit && MCmd == CMD_RD) ? rd_data : '0;
                end
                default: begin
                    if (MCmd != CMD_IDLE) begin
                        state      <= ACCEPT_DELAY == 0 ? S_ACCEPT : S_WAIT;
                        SCmdAccept <= ACCEPT_DELAY == 0;
                        cnt        <= 4'(ACCEPT_DELAY);
                    end else
                        state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ocp_slave_fsm.sv
// tb_ocp_slave_fsm: randomized self-checking bench for ocp_slave_fsm at accept delays 0 and 3
module tb_ocp_slave_fsm;
    import ocp_pkg::*;
    logic       Clk = 1'b0;
    logic       reset;
    logic       en    [2];
    logic [2:0] mcmd  [2];
    logic [63:0] mad  [2];
    logic [7:0] mdat  [2];
    logic       sacc  [2];
    logic [1:0] sresp [2];
    logic [7:0] sdat  [2];
    logic       err   [2];
    logic [7:0] mdl   [2][16];
    int total = 0;
    int bad   = 0;
    always #5 Clk = ~Clk;
    ocp_slave_fsm #(.ACCEPT_DELAY(0)) u0 (
        .Clk(Clk), .reset(reset), .EnableClk(en[0]), .MCmd(mcmd[0]), .MAddr(mad[0]), .MData(mdat[0]),
        .SCmdAccept(sacc[0]), .SResp(sresp[0]), .SData(sdat[0]), .err(err[0])
    );
    ocp_slave_fsm #(.ACCEPT_DELAY(3)) u3 (
        .Clk(Clk), .reset(reset), .EnableClk(en[1]), .MCmd(mcmd[1]), .MAddr(mad[1]), .MData(mdat[1]),
        .SCmdAccept(sacc[1]), .SResp(sresp[1]), .SData(sdat[1]), .err(err[1])
    );
    function automatic int dly(input int d);
        return d == 0 ? 0 : 3;
    endfunction
    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                mdl[d][i] = 8'h00;
    endtask
    // One full transaction: present, wait for accept, execute, then check response and its retirement
    task automatic run_txn(input int d, input logic [2:0] cmd, input logic [63:0] addr,
                           input logic [7:0] data, input int stall_at);
        logic [1:0] er;
        logic [7:0] ed;
        logic       ee;
        bit         hit;
        int         idx, n, lat;
        hit = addr[63:4] == 60'd0;
        idx = int'(addr[3:0]);
        er = RESP_NULL; ed = 8'h00; ee = 1'b0;
        case (cmd)
            CMD_WR:   ee = !hit;
            CMD_WRNP: begin er = hit ? RESP_DVA : RESP_ERR; ee = !hit; end
            CMD_RD:   begin er = hit ? RESP_DVA : RESP_ERR; ed = hit ? mdl[d][idx] : 8'h00; ee = !hit; end
            CMD_WRC:  begin er = RESP_FAIL; ee = 1'b1; end
            default:  begin er = RESP_ERR; ee = 1'b1; end
        endcase
        mcmd[d] = cmd; mad[d] = addr; mdat[d] = data;
        n = 0;
        while (n < 40) begin
            @(negedge Clk);
            n++;
            if (sacc[d]) break;
            if (n == stall_at) en[d] = 1'b0;
            if (n == stall_at + 2) en[d] = 1'b1;
        end
        en[d] = 1'b1;
        lat = dly(d) + 1 + ((stall_at > 0 && stall_at <= dly(d)) ? 2 : 0);
        total++; if (n !== lat) begin bad++; $display("FAIL accept_latency d=%0d cmd=%0d got=%0d exp=%0d", d, cmd, n, lat); end
        @(negedge Clk);
        mcmd[d] = CMD_IDLE;
        if ((cmd == CMD_WR || cmd == CMD_WRNP) && hit) mdl[d][idx] = data;
        total++; if (sacc[d] !== 1'b0) begin bad++; $display("FAIL accept_width d=%0d got=%b exp=0", d, sacc[d]); end
        total++; if (sresp[d] !== er) begin bad++; $display("FAIL resp d=%0d cmd=%0d addr=%h got=%0d exp=%0d", d, cmd, addr, sresp[d], er); end
        total++; if (sdat[d] !== ed) begin bad++; $display("FAIL sdata d=%0d cmd=%0d addr=%h got=%h exp=%h", d, cmd, addr, sdat[d], ed); end
        total++; if (err[d] !== ee) begin bad++; $display("FAIL err d=%0d cmd=%0d addr=%h got=%b exp=%b", d, cmd, addr, err[d], ee); end
        @(negedge Clk);
        total++; if ({sresp[d], sdat[d], err[d], sacc[d]} !== 12'h0) begin bad++; $display("FAIL retire d=%0d got resp=%0d data=%h err=%b acc=%b exp all 0", d, sresp[d], sdat[d], err[d], sacc[d]); end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b1; mcmd[d] = CMD_IDLE; mad[d] = '0; mdat[d] = '0;
        end
        clear_model();
        repeat (2) @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            total++; if (sacc[d] !== 1'b0) begin bad++; $display("FAIL reset_acc d=%0d got=%b exp=0", d, sacc[d]); end
            total++; if (sresp[d] !== RESP_NULL) begin bad++; $display("FAIL reset_resp d=%0d got=%0d exp=0", d, sresp[d]); end
            total++; if (sdat[d] !== 8'h00) begin bad++; $display("FAIL reset_data d=%0d got=%h exp=00", d, sdat[d]); end
            total++; if (err[d] !== 1'b0) begin bad++; $display("FAIL reset_err d=%0d got=%b exp=0", d, err[d]); end
        end
        reset = 1'b0;
    endtask
    task automatic test_write_read();
        run_txn(0, CMD_WR, 64'h3, 8'hA5, 0);
        run_txn(0, CMD_RD, 64'h3, 8'h00, 0);
    endtask
    task automatic test_delay();
        run_txn(1, CMD_RD, 64'h0, 8'h00, 0);
        run_txn(1, CMD_WR, 64'h9, 8'h5E, 0);
        run_txn(1, CMD_RD, 64'h9, 8'h00, 0);
    endtask
    task automatic test_miss();
        run_txn(0, CMD_RD, 64'h10, 8'h00, 0);
        run_txn(0, CMD_WR, 64'h10, 8'h5A, 0);
        run_txn(0, CMD_RD, 64'h0, 8'h00, 0);
        run_txn(0, CMD_WRNP, 64'h8000_0000_0000_0002, 8'h11, 0);
        run_txn(0, CMD_RD, 64'h2, 8'h00, 0);
    endtask
    task automatic test_wrc();
        run_txn(0, CMD_WRNP, 64'h7, 8'h3C, 0);
        run_txn(0, CMD_WRC, 64'h7, 8'hFF, 0);
        run_txn(0, CMD_RD, 64'h7, 8'h00, 0);
        run_txn(0, CMD_RDEX, 64'h7, 8'h00, 0);
        run_txn(0, CMD_BCST, 64'h7, 8'h00, 0);
    endtask
    task automatic test_back_to_back();
        logic [7:0] a, b;
        a = 8'($urandom); b = 8'($urandom);
        run_txn(0, CMD_WR, 64'h1, a, 0);
        run_txn(0, CMD_WR, 64'h2, b, 0);
        mcmd[0] = CMD_RD; mad[0] = 64'h1;
        @(negedge Clk);
        total++; if (sacc[0] !== 1'b1) begin bad++; $display("FAIL b2b_acc1 got=%b exp=1", sacc[0]); end
        @(negedge Clk);
        total++; if ({sresp[0], sdat[0]} !== {RESP_DVA, a}) begin bad++; $display("FAIL b2b_dva1 got=%0d/%h exp=1/%h", sresp[0], sdat[0], a); end
        mad[0] = 64'h2;
        @(negedge Clk);
        total++; if ({sresp[0], sacc[0]} !== {RESP_NULL, 1'b1}) begin bad++; $display("FAIL b2b_acc2 got resp=%0d acc=%b exp 0/1", sresp[0], sacc[0]); end
        @(negedge Clk);
        mcmd[0] = CMD_IDLE;
        total++; if ({sresp[0], sdat[0]} !== {RESP_DVA, b}) begin bad++; $display("FAIL b2b_dva2 got=%0d/%h exp=1/%h", sresp[0], sdat[0], b); end
        @(negedge Clk);
        total++; if (sresp[0] !== RESP_NULL) begin bad++; $display("FAIL b2b_retire got=%0d exp=0", sresp[0]); end
    endtask
    task automatic test_stall();
        run_txn(1, CMD_WR, 64'h4, 8'hC3, 1);
        run_txn(1, CMD_RD, 64'h4, 8'h00, 2);
    endtask
    task automatic test_violation();
        mcmd[1] = CMD_RD; mad[1] = 64'h0;
        @(negedge Clk);
        mcmd[1] = CMD_IDLE;
        @(negedge Clk);
        total++; if ({err[1], sacc[1]} !== 2'b10) begin bad++; $display("FAIL violation got err=%b acc=%b exp 1/0", err[1], sacc[1]); end
        @(negedge Clk);
        total++; if (err[1] !== 1'b0) begin bad++; $display("FAIL violation_pulse got=%b exp=0", err[1]); end
        repeat (4) begin
            @(negedge Clk);
            total++; if ({sacc[1], sresp[1]} !== 3'b000) begin bad++; $display("FAIL violation_quiet got acc=%b resp=%0d exp 0/0", sacc[1], sresp[1]); end
        end
    endtask
    task automatic test_random();
        int d;
        for (int k = 0; k < 60; k++) begin
            d = int'($urandom_range(0, 1));
            run_txn(d, 3'($urandom_range(1, 7)), 64'($urandom_range(0, 31)), 8'($urandom),
                    d == 1 ? int'($urandom_range(0, 3)) : 0);
        end
    endtask
    task automatic test_reset_mid();
        int n;
        run_txn(0, CMD_WR, 64'h5, 8'h77, 0);
        mcmd[0] = CMD_RD; mad[0] = 64'h5;
        n = 0;
        while (n < 10) begin
            @(negedge Clk);
            n++;
            if (sacc[0]) break;
        end
        total++; if (n !== 1) begin bad++; $display("FAIL rst_mid_acc got=%0d exp=1", n); end
        reset = 1'b1;
        @(negedge Clk);
        total++; if ({sacc[0], sresp[0]} !== 3'b000) begin bad++; $display("FAIL rst_mid got acc=%b resp=%0d exp 0/0", sacc[0], sresp[0]); end
        reset = 1'b0;
        mcmd[0] = CMD_IDLE;
        clear_model();
        repeat (4) begin
            @(negedge Clk);
            total++; if (sresp[0] !== RESP_NULL) begin bad++; $display("FAIL rst_mid_no_dva got=%0d exp=0", sresp[0]); end
        end
        run_txn(0, CMD_RD, 64'h5, 8'h00, 0);
        run_txn(1, CMD_RD, 64'h9, 8'h00, 0);
    endtask
    initial begin
        test_reset();
        test_write_read();
        test_delay();
        test_miss();
        test_wrc();
        test_back_to_back();
        test_stall();
        test_violation();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
